mul_iter: RTL and testbench

- Sequential radix-2 shift-add multiplier core for the M-extension.
- Sits directly upstream of the multiply output/sign-correction stage.
- Converts rs1/rs2 to unsigned magnitudes according to the op, and iterates 32 cycles to form the 64-bit unsigned magnitude product.
- Delivers product, operand sign bits and op to the sign-correction stage, which selects and negates the 32-bit result.

---
 rtl/mul_iter_pkg.sv | 18 +
 rtl/mul_operand_prep.sv | 27 ++
 rtl/mul_iter.sv | 116 +++++++++++
 tb/tb_mul_iter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mul_iter_pkg.sv
// rtl/mul_iter_pkg.sv - shared encodings and constants for the iterative multiplier
package mul_iter_pkg;

    localparam int MUL_XLEN = 32;
    localparam int ITER_CNT = 32;

    localparam logic [1:0] MUL_LO  = 2'b00;
    localparam logic [1:0] MUL_H   = 2'b01;
    localparam logic [1:0] MUL_HSU = 2'b10;
    localparam logic [1:0] MUL_HU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/mul_operand_prep.sv
// rtl/mul_operand_prep.sv - op-dependent sign extraction and operand magnitudes
module mul_operand_prep
    import mul_iter_pkg::*;
(
    input  logic [1:0]          op_mul,
    input  logic [MUL_XLEN-1:0] rs1,
    input  logic [MUL_XLEN-1:0] rs2,
    output logic                sign_a,
    output logic                sign_b,
    output logic [MUL_XLEN-1:0] mag_a,
    output logic [MUL_XLEN-1:0] mag_b
);

    logic a_signed;
    logic b_signed;

    assign a_signed = (op_mul != MUL_HU);
    assign b_signed = (op_mul == MUL_LO) || (op_mul == MUL_H);

    assign sign_a = rs1[MUL_XLEN-1] & a_signed;
    assign sign_b = rs2[MUL_XLEN-1] & b_signed;

    // Most negative value negates to itself, which is its correct unsigned magnitude.
    assign mag_a = sign_a ? (~rs1 + 1'b1) : rs1;
    assign mag_b = sign_b ? (~rs2 + 1'b1) : rs2;

endmodule

// File: rtl/mul_iter.sv
// rtl/mul_iter.sv - radix-2 shift-add magnitude multiplier feeding the sign-correction stage
module mul_iter
    import mul_iter_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              kill_i,
    input  logic [1:0]        op_mul_i,
    input  logic [XLEN-1:0]   rs1_i,
    input  logic [XLEN-1:0]   rs2_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [2*XLEN-1:0] p_o,
    output logic              m_ina32_o,
    output logic              m_inb32_o,
    output logic [1:0]        op_mul_o
);

    state_t          state;
    state_t          state_next;
    logic [XLEN-1:0] mcand;
    logic [2*XLEN:0] acc;
    logic [4:0]      cnt;

    logic            sign_a;
    logic            sign_b;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            zero_op;
    logic            accept;
    logic            last_iter;
    logic [XLEN:0]   hi;
    logic [2*XLEN:0] acc_shift;

    mul_operand_prep u_prep (
        .op_mul (op_mul_i),
        .rs1    (rs1_i),
        .rs2    (rs2_i),
        .sign_a (sign_a),
        .sign_b (sign_b),
        .mag_a  (mag_a),
        .mag_b  (mag_b)
    );

    assign zero_op   = (mag_a == '0) || (mag_b == '0);
    assign accept    = (state == IDLE) && start_i && !kill_i;
    assign last_iter = (cnt == 5'(ITER_CNT - 1));

    // Upper 33 bits absorb the conditional add; the low half shifts out the consumed multiplier bit.
    always_comb begin
        hi = acc[2*XLEN:XLEN];
        if (acc[0]) begin
            hi = acc[2*XLEN:XLEN] + {1'b0, mcand};
        end
        acc_shift = {1'b0, hi, acc[XLEN-1:1]};
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = zero_op ? DONE : RUN;
                end
            end
            RUN: begin
                if (kill_i) begin
                    state_next = IDLE;
                end else if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state     <= IDLE;
            mcand     <= '0;
            acc       <= '0;
            cnt       <= '0;
            p_o       <= '0;
            m_ina32_o <= 1'b0;
            m_inb32_o <= 1'b0;
            op_mul_o  <= 2'b00;
        end else begin
            state <= state_next;
            if (accept) begin
                m_ina32_o <= sign_a;
                m_inb32_o <= sign_b;
                op_mul_o  <= op_mul_i;
                mcand     <= mag_a;
                cnt       <= '0;
                acc       <= zero_op ? '0 : {{(XLEN+1){1'b0}}, mag_b};
                if (zero_op) begin
                    p_o <= '0;
                end
            end else if (state == RUN && !kill_i) begin
                acc <= acc_shift;
                cnt <= cnt + 5'd1;
                if (last_iter) begin
                    p_o <= acc_shift[2*XLEN-1:0];
                end
            end
        end
    end

    assign busy_o = (state != IDLE);
    assign done_o = (state == DONE) && !kill_i;

endmodule

// File: tb/tb_mul_iter.sv
// tb/tb_mul_iter.sv - self-checking bench for mul_iter against an arithmetic reference model
module tb_mul_iter;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        start_i;
    logic        kill_i;
    logic [1:0]  op_mul_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic        busy_o;
    logic        done_o;
    logic [63:0] p_o;
    logic        m_ina32_o;
    logic        m_inb32_o;
    logic [1:0]  op_mul_o;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] last_p;

    always #5 clk = ~clk;

    mul_iter #(.XLEN(32)) dut (
        .clk_i     (clk),
        .reset_i   (reset_i),
        .start_i   (start_i),
        .kill_i    (kill_i),
        .op_mul_i  (op_mul_i),
        .rs1_i     (rs1_i),
        .rs2_i     (rs2_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .p_o       (p_o),
        .m_ina32_o (m_ina32_o),
        .m_inb32_o (m_inb32_o),
        .op_mul_o  (op_mul_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_sign_a(input logic [1:0] op, input logic [31:0] a);
        return a[31] && (op != 2'b11);
    endfunction

    function automatic logic ref_sign_b(input logic [1:0] op, input logic [31:0] b);
        return b[31] && (op[1] == 1'b0);
    endfunction

    // Interpret operands as integers, take absolute values, multiply.
    function automatic logic [63:0] ref_prod(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        longint va;
        longint vb;
        longint unsigned ma;
        longint unsigned mb;
        va = ref_sign_a(op, a) ? longint'($signed(a)) : longint'({32'b0, a});
        vb = ref_sign_b(op, b) ? longint'($signed(b)) : longint'({32'b0, b});
        ma = (va < 0) ? longint'(-va) : va;
        mb = (vb < 0) ? longint'(-vb) : vb;
        return 64'(ma * mb);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit check_after);
        int          lat;
        logic [63:0] exp_p;
        exp_p = ref_prod(op, a, b);
        step();
        start_i  = 1'b1;
        op_mul_i = op;
        rs1_i    = a;
        rs2_i    = b;
        lat = 0;
        do begin
            step();
            start_i = 1'b0;
            lat++;
            if (lat == 1) chk("busy_after_accept", 64'(busy_o), 64'd1);
        end while (!done_o && lat < 40);
        chk("latency", 64'(lat), (a == 0 || b == 0) ? 64'd1 : 64'd33);
        chk("p_o", p_o, exp_p);
        chk("m_ina32_o", 64'(m_ina32_o), 64'(ref_sign_a(op, a)));
        chk("m_inb32_o", 64'(m_inb32_o), 64'(ref_sign_b(op, b)));
        chk("op_mul_o", 64'(op_mul_o), 64'(op));
        last_p = exp_p;
        if (check_after) begin
            step();
            chk("single_done_pulse", 64'(done_o), 64'd0);
            chk("idle_after_done", 64'(busy_o), 64'd0);
            chk("p_hold", p_o, exp_p);
        end
    endtask

    initial begin
        int          lat;
        bit          got;
        logic [31:0] ra;
        logic [31:0] rb;

        reset_i  = 1'b1;
        start_i  = 1'b0;
        kill_i   = 1'b0;
        op_mul_i = 2'b00;
        rs1_i    = '0;
        rs2_i    = '0;
        last_p   = '0;
        step();
        step();
        reset_i = 1'b0;
        chk("reset_busy", 64'(busy_o), 64'd0);
        chk("reset_done", 64'(done_o), 64'd0);
        chk("reset_p", p_o, 64'd0);
        chk("reset_signs", 64'({m_ina32_o, m_inb32_o}), 64'd0);
        chk("reset_op", 64'(op_mul_o), 64'd0);

        run_op(2'b00, 32'd7, 32'hFFFF_FFFD, 1'b1);
        chk("t1_p_const", p_o, 64'h0000_0000_0000_0015);
        run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        chk("t2_p_const", p_o, 64'hFFFF_FFFE_0000_0001);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        chk("t3_p_const", p_o, 64'h7FFF_FFFF_8000_0000);

        run_op(2'b01, 32'd0, 32'd5, 1'b0);
        run_op(2'b00, 32'd9, 32'hFFFF_FFF0, 1'b1);

        // Kill mid-run: no result, previous product retained, then a clean restart.
        step();
        start_i  = 1'b1;
        op_mul_i = 2'b00;
        rs1_i    = 32'd3;
        rs2_i    = 32'd4;
        for (int c = 1; c <= 10; c++) begin
            step();
            start_i = 1'b0;
        end
        kill_i = 1'b1;
        step();
        kill_i = 1'b0;
        chk("kill_busy", 64'(busy_o), 64'd0);
        chk("kill_done", 64'(done_o), 64'd0);
        chk("kill_p_hold", p_o, last_p);
        run_op(2'b00, 32'd3, 32'd4, 1'b1);
        chk("after_kill_p", p_o, 64'd12);

        // Start while busy must be ignored.
        step();
        start_i  = 1'b1;
        op_mul_i = 2'b00;
        rs1_i    = 32'h1234_5678;
        rs2_i    = 32'hFFFF_FF00;
        got = 1'b0;
        lat = 0;
        for (int c = 1; c <= 40 && !got; c++) begin
            step();
            start_i = (c == 5);
            if (c == 5) begin
                op_mul_i = 2'b11;
                rs1_i    = 32'd3;
                rs2_i    = 32'd3;
            end
            if (done_o) begin
                got = 1'b1;
                lat = c;
            end
        end
        chk("busy_start_latency", 64'(lat), 64'd33);
        chk("busy_start_p", p_o, ref_prod(2'b00, 32'h1234_5678, 32'hFFFF_FF00));
        chk("busy_start_op", 64'(op_mul_o), 64'd0);
        step();
        chk("busy_start_no_second", 64'(busy_o), 64'd0);

        // Reset mid-operation.
        step();
        start_i  = 1'b1;
        op_mul_i = 2'b10;
        rs1_i    = 32'h8000_0000;
        rs2_i    = 32'd5;
        for (int c = 1; c <= 20; c++) begin
            step();
            start_i = 1'b0;
        end
        chk("pre_reset_busy", 64'(busy_o), 64'd1);
        chk("pre_reset_op", 64'(op_mul_o), 64'd2);
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        chk("midreset_busy", 64'(busy_o), 64'd0);
        chk("midreset_done", 64'(done_o), 64'd0);
        chk("midreset_p", p_o, 64'd0);
        chk("midreset_signs", 64'({m_ina32_o, m_inb32_o}), 64'd0);
        chk("midreset_op", 64'(op_mul_o), 64'd0);

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 7))
                0:       ra = 32'd0;
                1:       ra = 32'h8000_0000;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'h8000_0000;
                default: rb = $urandom;
            endcase
            run_op(2'($urandom_range(0, 3)), ra, rb, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
